// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
// The data memory uses the same width defaults.
package riscv_mem_pkg;

    localparam int MEM_ADDR_W = 9;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef logic [1:0] arb_state_e;

    localparam arb_state_e IDLE = 2'd0;
    localparam arb_state_e REQ  = 2'd1;
    localparam arb_state_e RESP = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single-port memory: one transaction
// in flight, alternating ownership on contention, pipeline stalls and a transaction watchdog.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err_timeout
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    arb_state_e        state;
    owner_e            owner;
    owner_e            last_owner;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [15:0]       wd_cnt;
    logic              err;

    logic   busy;
    logic   done;
    logic   expire;
    logic   can_arb;
    logic   elig_if;
    logic   elig_d;
    logic   sel_valid;
    owner_e sel;

    // NOTE: every signal gets a value before any branch so no latch is inferred.
    always_comb begin
        sel       = OWN_IF;
        busy      = (state == REQ) || (state == RESP);
        done      = (state == RESP) && mem_rvalid;
        expire    = busy && !done && (wd_cnt == WD_LAST);
        can_arb   = !busy || done;
        // The completing owner still holds its req this cycle, so it sits out.
        elig_if   = can_arb && if_req && !(done && owner == OWN_IF);
        elig_d    = can_arb && d_req  && !(done && owner == OWN_D);
        sel_valid = elig_if || elig_d;
        if (elig_if && elig_d) begin
            sel = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (elig_d) begin
            sel = OWN_D;
        end
    end

    assign if_gnt      = sel_valid && (sel == OWN_IF);
    assign d_gnt       = sel_valid && (sel == OWN_D);

    assign mem_req     = (state == REQ);
    assign mem_we      = mem_req && lat_we;
    assign mem_addr    = lat_addr;
    assign mem_wdata   = lat_wdata;

    // A watchdog abort completes the owner with zero data.
    assign if_rvalid   = (done || expire) && (owner == OWN_IF);
    assign d_rvalid    = (done || expire) && (owner == OWN_D);
    assign if_rdata    = (done && owner == OWN_IF) ? mem_rdata : '0;
    assign d_rdata     = (done && owner == OWN_D)  ? mem_rdata : '0;

    assign stall_if    = if_req && !if_rvalid;
    assign stall_mem   = d_req  && !d_rvalid;
    assign err_timeout = err;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            wd_cnt     <= '0;
            err        <= 1'b0;
        end else if (sel_valid) begin
            state      <= REQ;
            owner      <= sel;
            last_owner <= sel;
            wd_cnt     <= '0;
            if (sel == OWN_D) begin
                lat_addr  <= d_addr;
                lat_we    <= d_we;
                lat_wdata <= d_wdata;
            end else begin
                // Fetches never write; their write data is cleared as well.
                lat_addr  <= if_addr;
                lat_we    <= 1'b0;
                lat_wdata <= '0;
            end
        end else if (done || expire) begin
            state <= IDLE;
            if (expire) begin
                err <= 1'b1;
            end
        end else if (busy) begin
            wd_cnt <= wd_cnt + 16'd1;
            if (state == REQ && mem_ready) begin
                state <= RESP;
            end
        end else begin
            state <= IDLE;
        end
    end

    // Requesters must hold req until their rvalid.
    a_if_req_held: assert property (@(posedge clk)
        (!reset && $past(!reset && if_req && !if_rvalid)) |-> if_req);
    a_d_req_held: assert property (@(posedge clk)
        (!reset && $past(!reset && d_req && !d_rvalid)) |-> d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, a behavioural memory with programmable latency, directed scenarios and random traffic.
module tb_mem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk;
    logic          reset;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we, mem_ready, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          stall_if, stall_mem, err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // ---------------- behavioural memory ----------------
    logic [DW-1:0] mem_arr [0:127];
    int mem_lat       = 1;
    bit mem_rand      = 0;
    bit mem_hang      = 0;
    int mem_force_low = 0;

    initial begin : memory
        bit            acc, a_we, pend;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wd, pdata;
        int            cnt, low_streak;
        pend = 0; cnt = 0; low_streak = 0; pdata = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            acc    = mem_req && mem_ready;
            a_we   = mem_we;
            a_addr = mem_addr;
            a_wd   = mem_wdata;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (acc && !mem_hang) begin
                if (a_we) mem_arr[a_addr[8:2]] = a_wd;
                pdata = mem_arr[a_addr[8:2]];
                pend  = 1;
                cnt   = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend       = 0;
                    mem_rvalid = 1'b1;
                    mem_rdata  = pdata;
                end
            end
            if (mem_force_low > 0) begin
                mem_ready = 1'b0;
                mem_force_low--;
            end else if (mem_rand && low_streak < 2 && $urandom_range(0, 3) == 0) begin
                mem_ready = 1'b0;
                low_streak++;
            end else begin
                mem_ready  = 1'b1;
                low_streak = 0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // One transaction record: who owns it, whether memory accepted it, and its age.
    bit            m_busy, m_acc, m_who, m_last, m_err;
    int            m_age;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;

    always @(negedge clk) begin : model_chk
        bit done, expire, can_arb, c_if, c_d, any, pick, e_ifv, e_dv;
        if (reset) begin
            m_busy = 0; m_acc = 0; m_who = 0; m_last = 0; m_err = 0; m_age = 0;
            m_addr = '0; m_we = 1'b0; m_wdata = '0;
        end else begin
            done    = m_busy && m_acc && mem_rvalid;
            expire  = m_busy && !done && (m_age == TO - 1);
            can_arb = !m_busy || done;
            c_if    = can_arb && if_req && !(done && !m_who);
            c_d     = can_arb && d_req  && !(done &&  m_who);
            any     = c_if || c_d;
            pick    = (c_if && c_d) ? !m_last : c_d;
            e_ifv   = (done || expire) && !m_who;
            e_dv    = (done || expire) &&  m_who;

            check("if_gnt",      if_gnt,      any && !pick);
            check("d_gnt",       d_gnt,       any &&  pick);
            check("mem_req",     mem_req,     m_busy && !m_acc);
            check("mem_we",      mem_we,      m_busy && !m_acc && m_we);
            check("mem_addr",    mem_addr,    m_addr);
            check("mem_wdata",   mem_wdata,   m_wdata);
            check("if_rvalid",   if_rvalid,   e_ifv);
            check("d_rvalid",    d_rvalid,    e_dv);
            check("if_rdata",    if_rdata,    (done && !m_who) ? mem_rdata : '0);
            check("d_rdata",     d_rdata,     (done &&  m_who) ? mem_rdata : '0);
            check("stall_if",    stall_if,    if_req && !e_ifv);
            check("stall_mem",   stall_mem,   d_req && !e_dv);
            check("err_timeout", err_timeout, m_err);

            if (any) begin
                m_busy  = 1; m_acc = 0; m_age = 0;
                m_who   = pick; m_last = pick;
                m_addr  = pick ? d_addr : if_addr;
                m_we    = pick ? d_we : 1'b0;
                m_wdata = pick ? d_wdata : '0;
            end else if (done || expire) begin
                m_busy = 0;
                if (expire) m_err = 1;
            end else if (m_busy) begin
                m_age++;
                if (!m_acc && mem_ready) m_acc = 1;
            end
        end
    end

    // ---------------- requester engine ----------------
    int if_left = 0, d_left = 0, req_pct = 100;
    bit if_seen = 0, d_seen = 0;
    int gnt_q[$];

    function automatic bit go();
        return $urandom_range(0, 99) < req_pct;
    endfunction

    task automatic step();
        tick();
        if (if_req && if_seen) begin
            if (if_left > 0 && go()) begin if_left--; if_addr = AW'($urandom); end
            else if_req = 1'b0;
        end else if (!if_req && if_left > 0 && go()) begin
            if_left--; if_req = 1'b1; if_addr = AW'($urandom);
        end
        if (d_req && d_seen) begin
            if (d_left > 0 && go()) begin
                d_left--; d_addr = AW'($urandom); d_we = 1'($urandom); d_wdata = $urandom;
            end else begin
                d_req = 1'b0; d_we = 1'b0;
            end
        end else if (!d_req && d_left > 0 && go()) begin
            d_left--; d_req = 1'b1; d_addr = AW'($urandom); d_we = 1'($urandom); d_wdata = $urandom;
        end
        settle();
        if_seen = if_rvalid;
        d_seen  = d_rvalid;
        if (if_gnt) gnt_q.push_back(0);
        if (d_gnt)  gnt_q.push_back(1);
    endtask

    function automatic bit engine_idle();
        return if_left == 0 && d_left == 0 && !if_req && !d_req;
    endfunction

    task automatic run_engine(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!engine_idle() && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_engine_finished"}, engine_idle(), 1'b1);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        settle();
        tick();
        settle();
        tick();
        reset = 1'b0;
        settle();
        if_seen = 0; d_seen = 0; if_left = 0; d_left = 0;
        gnt_q.delete();
    endtask

    initial begin : global_guard
        #1000000;
        $display("FAIL global_time_limit reached at %0t", $time);
        $fatal(1, "time limit");
    end

    // ---------------- directed scenarios + random traffic ----------------
    initial begin : main
        bit gap_chk;
        int comps, n;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 128; i++) mem_arr[i] = $urandom;
        mem_arr[4] = 32'h0050_0093;

        // Reset state
        do_reset();
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_gnts", {if_gnt, d_gnt}, 2'b00);
        check("rst_rvalids", {if_rvalid, d_rvalid}, 2'b00);
        check("rst_if_rdata", if_rdata, '0);
        check("rst_d_rdata", d_rdata, '0);
        check("rst_err", err_timeout, 1'b0);

        // Fetch only, 1-cycle memory
        tick(); if_req = 1'b1; if_addr = 9'h010; settle();
        check("t1_if_gnt", if_gnt, 1'b1);
        check("t1_stall_if_t0", stall_if, 1'b1);
        tick(); settle();
        check("t1_mem_req", mem_req, 1'b1);
        check("t1_mem_addr", mem_addr, 9'h010);
        check("t1_stall_if_t1", stall_if, 1'b1);
        tick(); settle();
        check("t1_if_rvalid", if_rvalid, 1'b1);
        check("t1_if_rdata", if_rdata, 32'h0050_0093);
        check("t1_stall_if_t2", stall_if, 1'b0);
        tick(); if_req = 1'b0; settle();

        // Tie right after reset: data first, fetch granted in the d_rvalid cycle
        do_reset();
        tick();
        if_req = 1'b1; if_addr = 9'h014;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h100;
        settle();
        check("t2_tie_gnts", {d_gnt, if_gnt}, 2'b10);
        tick(); settle();
        check("t2_mem_addr_d", mem_addr, 9'h100);
        tick(); settle();
        check("t2_d_rvalid", d_rvalid, 1'b1);
        check("t2_d_rdata", d_rdata, mem_arr[64]);
        check("t2_if_gnt_same_cycle", if_gnt, 1'b1);
        tick(); d_req = 1'b0; settle();
        check("t2_mem_req_if", mem_req, 1'b1);
        check("t2_mem_addr_if", mem_addr, 9'h014);
        tick(); settle();
        check("t2_if_rvalid", if_rvalid, 1'b1);
        check("t2_if_rdata", if_rdata, mem_arr[5]);
        tick(); if_req = 1'b0; settle();

        // Store with mem_ready low for 3 REQ cycles, fetch waiting behind it
        do_reset();
        mem_force_low = 4;
        tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 9'h104; d_wdata = 32'hDEAD_BEEF; settle();
        check("t3_d_gnt", d_gnt, 1'b1);
        tick(); if_req = 1'b1; if_addr = 9'h018; settle();
        for (int k = 0; k < 4; k++) begin
            check("t3_hold_mem_req", mem_req, 1'b1);
            check("t3_hold_mem_addr", mem_addr, 9'h104);
            check("t3_hold_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("t3_hold_mem_we", mem_we, 1'b1);
            check("t3_no_if_gnt", if_gnt, 1'b0);
            if (k < 3) begin tick(); settle(); end
        end
        tick(); settle();
        check("t3_d_rvalid", d_rvalid, 1'b1);
        check("t3_if_gnt_after", if_gnt, 1'b1);
        tick(); d_req = 1'b0; d_we = 1'b0; settle();
        check("t3_if_mem_addr", mem_addr, 9'h018);
        check("t3_if_mem_we", mem_we, 1'b0);
        tick(); settle();
        check("t3_if_rvalid", if_rvalid, 1'b1);
        tick(); if_req = 1'b0; settle();
        check("t3_store_landed", mem_arr[65], 32'hDEAD_BEEF);

        // Both held continuously for 6 transactions: strict alternation, no idle gap
        do_reset();
        mem_rand = 1; req_pct = 100; if_left = 3; d_left = 3;
        gap_chk = 0; comps = 0; n = 0;
        while (!engine_idle() && n < 200) begin
            step();
            n++;
            if (gap_chk) begin
                check("t4_no_idle_gap", mem_req, 1'b1);
                gap_chk = 0;
            end
            if ((if_rvalid || d_rvalid) && comps < 5) begin
                comps++;
                gap_chk = 1;
            end
        end
        check("t4_engine_finished", engine_idle(), 1'b1);
        check("t4_grant_count", gnt_q.size(), 6);
        for (int i = 0; i < gnt_q.size() && i < 6; i++)
            check("t4_grant_order", gnt_q[i], (i % 2 == 0) ? 1 : 0);
        mem_rand = 0;

        // Watchdog: memory accepts but never responds
        do_reset();
        mem_lat = 1; mem_hang = 1;
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020; settle();
        check("t5_d_gnt", d_gnt, 1'b1);
        for (int k = 1; k <= TO; k++) begin
            tick(); settle();
            if (k < TO) check("t5_no_early_rvalid", d_rvalid, 1'b0);
        end
        check("t5_abort_rvalid", d_rvalid, 1'b1);
        check("t5_abort_rdata", d_rdata, '0);
        check("t5_err_not_yet", err_timeout, 1'b0);
        tick(); d_req = 1'b0; settle();
        check("t5_err_set", err_timeout, 1'b1);
        check("t5_idle_after_abort", mem_req, 1'b0);
        mem_hang = 0;
        tick(); if_req = 1'b1; if_addr = 9'h010; settle();
        check("t5_next_if_gnt", if_gnt, 1'b1);
        tick(); settle();
        tick(); settle();
        check("t5_next_if_rvalid", if_rvalid, 1'b1);
        check("t5_next_if_rdata", if_rdata, 32'h0050_0093);
        check("t5_err_sticky", err_timeout, 1'b1);
        tick(); if_req = 1'b0; settle();
        check("t5_err_still_sticky", err_timeout, 1'b1);

        // Reset during RESP; memory answers the cycle after reset drops
        do_reset();
        check("t6_err_cleared", err_timeout, 1'b0);
        mem_lat = 2;
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 9'h030; settle();
        check("t6_d_gnt", d_gnt, 1'b1);
        tick(); settle();
        check("t6_mem_req", mem_req, 1'b1);
        tick(); reset = 1'b1; d_req = 1'b0; settle();
        tick(); reset = 1'b0; settle();
        check("t6_no_d_rvalid", d_rvalid, 1'b0);
        check("t6_no_if_rvalid", if_rvalid, 1'b0);
        check("t6_mem_req", mem_req, 1'b0);
        check("t6_mem_we", mem_we, 1'b0);
        check("t6_mem_addr", mem_addr, '0);
        check("t6_mem_wdata", mem_wdata, '0);
        check("t6_d_rdata", d_rdata, '0);
        mem_lat = 1; req_pct = 100; if_left = 1; d_left = 1;
        if_seen = 0; d_seen = 0; gnt_q.delete();
        run_engine(50, "t6");
        check("t6_tie_grants", gnt_q.size(), 2);
        if (gnt_q.size() > 0) check("t6_tie_data_first", gnt_q[0], 1);

        // Random traffic against the model
        do_reset();
        mem_rand = 1; req_pct = 35; if_left = 40; d_left = 40;
        run_engine(4000, "rand");
        mem_rand = 0;
        repeat (3) begin tick(); settle(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the instruction-fetch requester and the load/store requester.
- The load/store requester is driven by the MemRead/MemWrite decode of the main Controller.
- Serialises accesses with one transaction outstanding at a time, alternates ownership on contention, and raises per-requester stall signals for the pipeline.
- A watchdog aborts hung memory transactions and flags a sticky error.

Parameters:
- ADDR_W, 9, byte-address width on all address ports.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 64, max cycles a transaction may spend in REQ+RESP before abort; legal range 4..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_rvalid.
- if_addr  in  ADDR_W  fetch address; stable while if_req high.
- if_gnt  out  1  one-cycle pulse: fetch request latched.
- if_rvalid  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  DATA_W  fetch data; valid with if_rvalid.
- d_req  in  1  data request (MemRead|MemWrite); held high until d_rvalid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request latched.
- d_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged.
- d_rdata  out  DATA_W  load data; valid with d_rvalid.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts the request when mem_req & mem_ready.
- mem_rvalid  in  1  memory response; exactly one per accepted request.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  if_req & ~if_rvalid.
- stall_mem  out  1  d_req & ~d_rvalid.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- States: IDLE, REQ, RESP. Registers: owner {OWN_IF, OWN_D}, last_owner, latched addr/we/wdata, 16-bit wd_cnt, err.
- Reset (synchronous, any state): state = IDLE, owner = last_owner = OWN_IF, wd_cnt = 0, err = 0, all latches 0.
  - Outputs after reset: mem_req/mem_we/gnt/rvalid = 0, mem_addr/mem_wdata/rdata = 0, err_timeout = 0.
  - Reset mid-transaction discards it; a late mem_rvalid arriving in IDLE is ignored.
- Arbitration (IDLE; also RESP on completion):
  - Only one requester eligible: select it.
  - Both eligible: select the one != last_owner. Since last_owner resets to OWN_IF, data wins the first tie.
  - On selection: pulse the matching gnt; latch addr/we/wdata (fetch forces we = 0); owner <= selected; last_owner <= selected; next state REQ.
- REQ:
  - mem_req = 1; mem_addr/mem_we/mem_wdata come from the latches and stay stable until accept.
  - mem_ready = 1 gives RESP next cycle. mem_rvalid in REQ is ignored.
- RESP:
  - mem_req = 0.
  - On mem_rvalid: pulse owner's rvalid the same cycle; owner's rdata = mem_rdata (combinational pass-through; non-owner rdata = 0).
  - Re-arbitrate in the same cycle with the current owner excluded, because its req is still high in this cycle. Other side pending gives REQ; otherwise IDLE.
- Latency: request seen in IDLE at cycle t gives gnt at t, mem_req at t+1, and rvalid no earlier than t+2 (mem_ready=1 at t+1, mem_rvalid=1 at t+2).
- Store completion is signalled by mem_rvalid like a load; d_rdata is don't-care (drive mem_rdata).
- Watchdog:
  - wd_cnt clears on entry to REQ and increments every cycle in REQ/RESP.
  - When wd_cnt == TIMEOUT_CYC-1 without completion: pulse owner's rvalid with rdata = 0, set err (sticky until reset), go IDLE.
  - Completion in that same cycle takes precedence: normal rvalid, no error.
- stall_if and stall_mem are combinational, derived from req and rvalid only.
- Requester protocol violations (dropping req before rvalid) are out of scope; assertions flag them in simulation.

Decomposition:
- Package riscv_mem_pkg: owner_e {OWN_IF, OWN_D}, arb_state_e {IDLE, REQ, RESP}, default ADDR_W/DATA_W constants shared with the data memory.
- No sub-module is needed. The watchdog is an inline counter in the same always_ff as the FSM.

Test Plan:
- Fetch only, if_addr=0x010, mem_ready=1, 1-cycle memory: if_gnt at t, mem_req/mem_addr=0x010 at t+1, if_rvalid with if_rdata=0x00500093 at t+2; stall_if high t..t+1.
- Simultaneous if_req (0x014) and d_req load (0x100) right after reset: data granted first, d_rvalid first; fetch enters REQ in the d_rvalid cycle; if_rvalid 2 cycles later.
- Store d_we=1, d_addr=0x104, d_wdata=0xDEADBEEF, mem_ready low 3 cycles: mem_req/mem_addr/mem_wdata/mem_we held stable 4 cycles; d_rvalid on the ack; no fetch grant meanwhile.
- Both requesters held continuously for 6 transactions: grants strictly alternate D,IF,D,IF,D,IF; no idle cycle between RESP completion and next REQ.
- TIMEOUT_CYC=8, mem_rvalid never asserted: owner rvalid pulses with rdata=0 at the 8th REQ/RESP cycle; err_timeout=1 and stays 1; next request proceeds normally.
- Reset asserted in RESP, mem_rvalid arrives the cycle after reset deasserts: no rvalid, all outputs 0, state IDLE; next tie goes to data.
